// File: rtl/dma_pkg.sv
// Shared definitions for the 2-D DMA engine: FSM encoding and default widths.
package dma_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  localparam int AW_DEF   = 14;
  localparam int SZW0_DEF = 7;
  localparam int STW0_DEF = 1;
  localparam int SZW1_DEF = 5;
  localparam int STW1_DEF = 7;

endpackage

// File: rtl/dma_dim2_arb_rr_arb.sv
// Round-robin one-hot picker: first request at or above ptr, modulo NREQ.
module rr_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  int k;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    k   = 0;
    for (int i = 0; i < NREQ; i++) begin
      k = (int'(ptr) + i) % NREQ;
      if (!any && req[k]) begin
        any    = 1'b1;
        gnt[k] = 1'b1;
        idx    = IDW'(k);
      end
    end
  end

endmodule

// File: rtl/dma_dim2_arb.sv
// Shares one dma_dim2 generator among NREQ descriptor requesters.
// DMA_ARB_ZERO_SKIP_EN: complete zero-size descriptors without the generator.
module dma_dim2_arb
  import dma_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int AW   = AW_DEF,
  parameter int SZW0 = SZW0_DEF,
  parameter int STW0 = STW0_DEF,
  parameter int SZW1 = SZW1_DEF,
  parameter int STW1 = STW1_DEF,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*AW-1:0]   req_base,
  input  logic [NREQ*SZW0-1:0] req_dim0_size,
  input  logic [NREQ*STW0-1:0] req_dim0_step,
  input  logic [NREQ*SZW1-1:0] req_dim1_size,
  input  logic [NREQ*STW1-1:0] req_dim1_step,
  output logic [NREQ-1:0]      done,
  output logic [AW-1:0]        gen_base,
  output logic [SZW0-1:0]      gen_dim0_size,
  output logic [STW0-1:0]      gen_dim0_step,
  output logic [SZW1-1:0]      gen_dim1_size,
  output logic [STW1-1:0]      gen_dim1_step,
  output logic                 gen_start_valid,
  input  logic                 gen_start_ready,
  input  logic                 gen_s_valid,
  input  logic                 gen_s_ready,
  input  logic                 gen_s_last,
  output logic [IDW-1:0]       owner,
  output logic                 busy
);

  logic [1:0]      state;
  logic [IDW-1:0]  ptr;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gidx;
  logic            gany;
  logic            fin;
  logic            zero;

  function automatic logic [IDW-1:0] nxt(input logic [IDW-1:0] i);
    return (i == IDW'(NREQ-1)) ? '0 : i + 1'b1;
  endfunction

  rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req (req_valid),
    .ptr (ptr),
    .gnt (gnt),
    .idx (gidx),
    .any (gany)
  );

  assign req_ready       = (state == ST_IDLE) ? gnt : '0;
  assign gen_start_valid = (state == ST_START);
  assign fin = (state == ST_RUN) && gen_s_valid
             && gen_s_ready && gen_s_last;

`ifdef DMA_ARB_ZERO_SKIP_EN
  assign zero = (req_dim0_size[gidx*SZW0 +: SZW0] == '0)
             || (req_dim1_size[gidx*SZW1 +: SZW1] == '0);
`else
  assign zero = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      ptr           <= '0;
      owner         <= '0;
      busy          <= 1'b0;
      done          <= '0;
      gen_base      <= '0;
      gen_dim0_size <= '0;
      gen_dim0_step <= '0;
      gen_dim1_size <= '0;
      gen_dim1_step <= '0;
    end else begin
      done <= '0;
      unique case (state)
        ST_IDLE: begin
          if (gany) begin
            gen_base      <= req_base[gidx*AW +: AW];
            gen_dim0_size <= req_dim0_size[gidx*SZW0 +: SZW0];
            gen_dim0_step <= req_dim0_step[gidx*STW0 +: STW0];
            gen_dim1_size <= req_dim1_size[gidx*SZW1 +: SZW1];
            gen_dim1_step <= req_dim1_step[gidx*STW1 +: STW1];
            owner         <= gidx;
            // empty descriptor retires at once, generator untouched
            if (zero) begin
              done <= gnt;
              ptr  <= nxt(gidx);
            end else begin
              busy  <= 1'b1;
              state <= ST_START;
            end
          end
        end
        ST_START: begin
          if (gen_start_ready) state <= ST_RUN;
        end
        ST_RUN: begin
          if (fin) begin
            done[owner] <= 1'b1;
            busy        <= 1'b0;
            ptr         <= nxt(owner);
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
